// File: rtl/char_tile_writer_if.sv
// Character-load stream and framebuffer write-port bundle for char_tile_writer.
// master = loader/framebuffer side, slave = the tile writer.
interface char_tile_writer_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned X_WIDTH    = 5,
    parameter int unsigned Y_WIDTH    = 5
);
    localparam int unsigned CHAR_ADDR_SIZE = X_WIDTH + Y_WIDTH;
    localparam int unsigned FB_ADDR_WIDTH  = 2 * CHAR_ADDR_SIZE;

    logic [DATA_WIDTH-1:0]     in_data;
    logic [CHAR_ADDR_SIZE-1:0] in_address;
    logic                      in_load_enable;
    logic [X_WIDTH-1:0]        in_x;
    logic [Y_WIDTH-1:0]        in_y;
    logic                      fb_we;
    logic [FB_ADDR_WIDTH-1:0]  fb_addr;
    logic [DATA_WIDTH-1:0]     fb_data;
    logic                      busy;
    logic                      tile_done;
    logic                      tile_abort;
    logic                      seq_error;

    modport master (
        output in_data, in_address, in_load_enable, in_x, in_y,
        input  fb_we, fb_addr, fb_data, busy, tile_done, tile_abort, seq_error
    );

    modport slave (
        input  in_data, in_address, in_load_enable, in_x, in_y,
        output fb_we, fb_addr, fb_data, busy, tile_done, tile_abort, seq_error
    );
endinterface

// File: rtl/char_tile_writer.sv
// Receives a character tile from the ROM loader and writes it into the framebuffer.
// Optional feature: define CHAR_TILE_TRANSPARENT_EN to skip writes of the key colour.
module char_tile_writer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned X_WIDTH    = 5,
    parameter int unsigned Y_WIDTH    = 5
`ifdef CHAR_TILE_TRANSPARENT_EN
    ,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F
`endif
) (
    input logic              clock,
    input logic              reset,
    char_tile_writer_if.slave tile_io
);
    localparam int unsigned CHAR_ADDR_SIZE = X_WIDTH + Y_WIDTH;
    localparam int unsigned FB_ADDR_WIDTH  = 2 * CHAR_ADDR_SIZE;
    localparam int unsigned CNT_W          = CHAR_ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0] CHAR_SIZE = CNT_W'(1) << CHAR_ADDR_SIZE;

    typedef enum logic [1:0] {StIdle, StRecv, StHold} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d, count_inc;
    logic [X_WIDTH-1:0]        x_lat_q, x_lat_d, x_sel;
    logic [Y_WIDTH-1:0]        y_lat_q, y_lat_d, y_sel;
    logic                      accept, wr_en;
    logic                      done_q, done_d, abort_q, abort_d, seq_q, seq_d;
    logic                      s1_we_q;
    logic [FB_ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0]     s1_data_q;
    logic                      fb_we_q;
    logic [FB_ADDR_WIDTH-1:0]  fb_addr_q;
    logic [DATA_WIDTH-1:0]     fb_data_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        x_lat_d   = x_lat_q;
        y_lat_d   = y_lat_q;
        accept    = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        count_inc = count_q + CNT_W'(1);
        case (state_q)
            StIdle: begin
                if (tile_io.in_load_enable) begin
                    accept  = 1'b1;
                    x_lat_d = tile_io.in_x;
                    y_lat_d = tile_io.in_y;
                    count_d = CNT_W'(1);
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (tile_io.in_load_enable) begin
                    accept = 1'b1;
                    if (count_inc == CHAR_SIZE) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        state_d = StHold;
                    end else begin
                        count_d = count_inc;
                    end
                end else begin
                    abort_d = 1'b1;
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (!tile_io.in_load_enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The first word of a tile uses the live x/y; they are being latched on the same edge.
    always_comb begin
        x_sel     = (state_q == StIdle) ? tile_io.in_x : x_lat_q;
        y_sel     = (state_q == StIdle) ? tile_io.in_y : y_lat_q;
        s1_addr_d = {y_sel, tile_io.in_address[CHAR_ADDR_SIZE-1:X_WIDTH],
                     x_sel, tile_io.in_address[X_WIDTH-1:0]};
        seq_d     = accept && (tile_io.in_address != count_q[CHAR_ADDR_SIZE-1:0]);
`ifdef CHAR_TILE_TRANSPARENT_EN
        wr_en     = accept && (tile_io.in_data != TRANSPARENT_COLOR);
`else
        wr_en     = accept;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            x_lat_q   <= '0;
            y_lat_q   <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            seq_q     <= 1'b0;
            s1_we_q   <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            seq_q   <= seq_d;
            s1_we_q <= wr_en;
            fb_we_q <= s1_we_q;
            if (wr_en) begin
                s1_addr_q <= s1_addr_d;
                s1_data_q <= tile_io.in_data;
            end
            if (s1_we_q) begin
                fb_addr_q <= s1_addr_q;
                fb_data_q <= s1_data_q;
            end
        end
    end

    assign tile_io.fb_we      = fb_we_q;
    assign tile_io.fb_addr    = fb_addr_q;
    assign tile_io.fb_data    = fb_data_q;
    assign tile_io.busy       = (state_q != StIdle);
    assign tile_io.tile_done  = done_q;
    assign tile_io.tile_abort = abort_q;
    assign tile_io.seq_error  = seq_q;
endmodule
